// File: rtl/booth_pkg.sv
// booth_pkg: FSM states, Booth digit encoding and iteration count shared by the multiplier.
// Define BOOTH_RADIX4_EN to build the radix-4 variant; radix-2 otherwise.
package booth_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;
`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif
  localparam int SHIFT = RADIX4 ? 2 : 1;
  function automatic int iter_f(input int n);
    return RADIX4 ? n / 2 + 1 : n + 2;
  endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps the multiplier window {Q1,Q0,q_m1} to a Booth digit and its addend.
module booth_recoder import booth_pkg::*; #(
  parameter int M = 10
) (
  input  logic [2:0]   win_i,
  input  logic [M-1:0] x_i,
  output logic [M:0]   addend_o
);
  digit_t     d;
  logic [M:0] mag;
  always_comb begin
    d.neg    = RADIX4 ? win_i[2] & ~(win_i[1] & win_i[0]) : win_i[1] & ~win_i[0];
    d.one    = win_i[1] ^ win_i[0];
    d.two    = RADIX4 & ((win_i == 3'b011) | (win_i == 3'b100));
    mag      = d.one ? {x_i[M-1], x_i} : d.two ? {x_i, 1'b0} : '0;
    addend_o = d.neg ? -mag : mag;
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, one add+shift per cycle, signed or unsigned per operation.
// BOOTH_RADIX4_EN selects radix-4 recoding (half the iterations); default is radix-2.
module booth_mult_seq import booth_pkg::*; #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           data_ready,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           o_busy,
  output logic           o_result_ready,
  output logic [2*N-1:0] o_product,
  output logic [1:0]     o_state
);
  localparam int M    = N + 2;
  localparam int ITER = iter_f(N);
  localparam int CW   = $clog2(M) + 1;
  state_t         state_q, state_d;
  logic [M:0]     a_q, a_d, addend, sum;
  logic [M-1:0]   q_q, q_d, x_q, x_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [2*M+1:0] shifted;
  function automatic logic [M-1:0] ext(input logic [N-1:0] v, input logic s);
    return s ? {{2{v[N-1]}}, v} : {2'b00, v};
  endfunction
  booth_recoder #(.M(M)) u_rec (
    .win_i    ({q_q[1:0], qm1_q}),
    .x_i      (x_q),
    .addend_o (addend)
  );
  always_comb begin
    sum     = a_q + addend;
    shifted = $signed({sum, q_q, qm1_q}) >>> SHIFT;
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (data_ready) begin
        state_d = CALC;
        a_d     = '0;
        q_d     = ext(multiplier, is_signed);
        qm1_d   = 1'b0;
        x_d     = ext(multiplicand, is_signed);
        cnt_d   = '0;
      end
      CALC: begin
        a_d   = shifted[2*M+1 -: M+1];
        q_d   = shifted[M:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q + 1'b1;
        // Capture on the last iteration so the product is valid alongside the DONE pulse.
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
          prod_d  = shifted[2*N:1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      x_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  assign o_busy         = state_q != IDLE;
  assign o_result_ready = state_q == DONE;
  assign o_product      = prod_q;
  assign o_state        = state_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed checks of the Booth multiplier in either radix build.
module tb_booth_mult_seq;
  localparam int N = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = N / 2 + 1;
`else
  localparam int ITER = N + 2;
`endif
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_ready = 1'b0;
  logic          is_signed = 1'b0;
  logic [N-1:0]  multiplicand = '0;
  logic [N-1:0]  multiplier = '0;
  logic          o_busy, o_result_ready;
  logic [2*N-1:0] o_product;
  logic [1:0]    o_state;
  int n_chk = 0;
  int n_fail = 0;

  booth_mult_seq #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_ready     (data_ready),
    .is_signed      (is_signed),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .o_busy         (o_busy),
    .o_result_ready (o_result_ready),
    .o_product      (o_product),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
    int lat;
    @(negedge clk);
    is_signed = s; multiplicand = x; multiplier = y; data_ready = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    data_ready = 1'b0; is_signed = ~s; multiplicand = ~x; multiplier = ~y;
    while (!o_result_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, ITER + 1);
    check({tag, "_prod"}, o_product, exp);
    check({tag, "_busy"}, o_busy, 1'b1);
    @(posedge clk); #1;
    check({tag, "_pulse1"}, o_result_ready, 1'b0);
    check({tag, "_hold"}, o_product, exp);
  endtask

  initial begin
    int p1, p2;
    logic [15:0] pr1, pr2;
    int unstable;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", o_busy, 1'b0);
    check("rst_rdy", o_result_ready, 1'b0);
    check("rst_prod", o_product, 16'h0);
    check("rst_state", o_state, 2'd0);
    @(negedge clk); reset = 1'b1;

    run_op("s7xm3",    1'b1, 8'd7,   8'hFD, 16'hFFEB);
    run_op("u255sq",   1'b0, 8'hFF,  8'hFF, 16'hFE01);
    run_op("s80sq",    1'b1, 8'h80,  8'h80, 16'h4000);
    run_op("s80x7f",   1'b1, 8'h80,  8'h7F, 16'hC080);
    run_op("u0xab",    1'b0, 8'h00,  8'hAB, 16'h0000);
    run_op("u80x7f",   1'b0, 8'h80,  8'h7F, 16'h3F80);
    run_op("sm1sq",    1'b1, 8'hFF,  8'hFF, 16'h0001);
    run_op("s7fsq",    1'b1, 8'h7F,  8'h7F, 16'h3F01);
    run_op("sm1x1",    1'b1, 8'hFF,  8'h01, 16'hFFFF);
    run_op("uffx1",    1'b0, 8'hFF,  8'h01, 16'h00FF);

    // data_ready held high, x = edge index + 1, y = 3: only IDLE-sampled pairs are computed.
    p1 = -1; p2 = -1; pr1 = '0; pr2 = '0; unstable = 0;
    @(negedge clk);
    is_signed = 1'b0; multiplier = 8'd3; multiplicand = 8'd1; data_ready = 1'b1;
    for (int k = 0; k < 2 * ITER + 4; k++) begin
      @(posedge clk); #1;
      multiplicand = 8'(k + 2);
      if (o_result_ready && p1 < 0) begin p1 = k; pr1 = o_product; end
      else if (o_result_ready && p2 < 0) begin p2 = k; pr2 = o_product; end
      else if (p1 >= 0 && p2 < 0 && o_product !== pr1) unstable++;
    end
    data_ready = 1'b0;
    check("hold_p1", p1, ITER);
    check("hold_prod1", pr1, 16'd3);
    check("hold_p2", p2, 2 * ITER + 2);
    check("hold_prod2", pr2, 16'(3 * (ITER + 3)));
    check("hold_stable", unstable, 0);
    repeat (3) @(posedge clk);

    // Reset three cycles into CALC.
    @(negedge clk);
    is_signed = 1'b1; multiplicand = 8'd7; multiplier = 8'hFD; data_ready = 1'b1;
    @(posedge clk); #1 data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_rdy", o_result_ready, 1'b0);
    check("abort_prod", o_product, 16'h0);
    check("abort_state", o_state, 2'd0);
    p1 = 0;
    repeat (ITER + 2) begin
      @(posedge clk); #1;
      if (o_result_ready) p1++;
    end
    check("abort_nopulse", p1, 0);
    @(negedge clk); reset = 1'b1;
    run_op("post_rst", 1'b1, 8'h9C, 8'h05, 16'hFE0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential Booth multiplier: control FSM, partial-product accumulator and multiplier shift register in one block.
- Successor to the fixed radix-2 Booth control unit; generalised width, signed/unsigned mode per operation, one combined add/shift per cycle.
- Optional radix-4 recoding halves the iteration count.
- Sits in the arithmetic datapath between the operand registers and the result bus.

Parameters:
- N, 8, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- data_ready  input  1  operands valid; accepted only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- multiplicand  input  N  operand X
- multiplier  input  N  operand Y
- o_busy  output  1  high from the cycle after accept through the DONE cycle
- o_result_ready  output  1  one-cycle pulse; product valid
- o_product  output  2N  X*Y, held stable until the next accept
- o_state  output  2  current FSM state, for debug

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: state IDLE, o_busy 0, o_result_ready 0, o_product 0, all internal registers 0.
- Internal widths: M = N+2.
  - X and Y are extended to M bits: sign-extended if is_signed, zero-extended otherwise.
  - Accumulator A is M+1 bits, shift register Q is M bits, plus a guard bit q_m1 (the appended zero).
- Iteration count ITER = M (radix-2) or M/2 (radix-4).
- FSM states: IDLE=0, CALC=1, DONE=2. Code 3 is illegal and recovers to IDLE.
- IDLE:
  - On data_ready=1: load Q=ext(Y), A=0, q_m1=0, latch ext(X), counter=0, go to CALC.
  - Otherwise stay in IDLE.
  - o_product is untouched in IDLE.
- CALC, one iteration per cycle:
  - Recode the digit from {Q[0], q_m1}, or {Q[1], Q[0], q_m1} in radix-4.
  - A += digit*ext(X), computed at M+1 bits.
  - Arithmetic right shift of {A, Q, q_m1} by 1 (radix-2) or 2 (radix-4).
  - counter += 1; go to DONE when counter == ITER-1.
- DONE:
  - o_product <= low 2N bits of {A, Q}.
  - o_result_ready = 1 for exactly this cycle; go to IDLE.
- Latency: the accept edge is the clock edge that samples data_ready=1 in IDLE. o_result_ready rises ITER+1 edges after it.
  - Radix-2, N=8: 11 cycles.
  - Radix-4, N=8: 6 cycles.
- Throughput: the next accept happens no earlier than the IDLE cycle after DONE. data_ready in CALC or DONE is ignored, not queued.
- Result width: the product always fits in 2N bits in both modes; no overflow flag.
- Operand capture: a change of is_signed or operands after accept has no effect on the running operation.
- Reset mid-operation: immediate abort to the reset values; no result_ready pulse.
- Counter width is clog2(M)+1 bits and never wraps within an operation.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined: radix-4 modified Booth, digits in {-2,-1,0,+1,+2}, shift by 2 per cycle, ITER = N/2+1.
- Undefined: radix-2 Booth, digits in {-1,0,+1}, shift by 1, ITER = N+2.
- Port list and results are identical in both builds; only latency differs.

Decomposition:
- Shared package booth_pkg holds:
  - state localparams IDLE/CALC/DONE
  - digit encoding (3-bit signed: neg, one, two)
  - ITER computation function
- One sub-module: booth_recoder, purely combinational. Maps the 2- or 3-bit window to a digit and produces the selected addend (0, ±X, ±2X) at M+1 bits.

Test Plan:
- N=8, is_signed=1, X=7, Y=-3 (0xFD) -> o_product=0xFFEB after ITER+1 cycles; o_result_ready high exactly 1 cycle.
- N=8, is_signed=0, X=255, Y=255 -> o_product=0xFE01; is_signed=1, X=0x80, Y=0x80 -> 0x4000.
- N=8, is_signed=1, X=0x80, Y=0x7F -> 0xC080; is_signed=0, X=0, Y=0xAB -> 0x0000.
- data_ready held high throughout with new operands each cycle -> only the IDLE-sampled pair is computed; accepts spaced ITER+2 cycles apart; o_product stable between pulses.
- Assert reset 3 cycles into CALC -> o_busy, o_result_ready and o_product read 0 asynchronously; after release the next operation completes correctly.
- Random sweep of 10k operand pairs and modes, in both BOOTH_RADIX4_EN builds, against a reference model -> zero mismatches; measured latency 11 cycles (radix-2) and 6 cycles (radix-4).
